// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings, port indices and RAM geometry for the data-RAM arbiter
package cpu_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_DONE = ST_DONE
  } arb_state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int RAM_ADDR_W = 3;
  localparam int RAM_DATA_W = 16;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: chooses the next RAM owner from two requests, optionally excluding the current owner
module ram_arb_pick
  import cpu_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  input  logic exclude_valid,
  input  logic exclude_idx,
  output logic grant_valid,
  output logic grant_idx
);
  logic r0, r1;
  // Masked requests; on a tie either port 0 or the port not served last wins
  always_comb begin
    r0 = req0 && !(exclude_valid && exclude_idx == PORT_CPU);
    r1 = req1 && !(exclude_valid && exclude_idx == PORT_DBG);
    grant_valid = r0 || r1;
    grant_idx = (r0 && r1) ? (FIXED_PRI ? PORT_CPU : !last_owner) : r1;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two requesters onto the single-port data RAM, one access per grant
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_t state, state_nx;
  logic owner, last_owner, l_we, grant_valid, grant_idx, take;
  ram_arb_pick #(.FIXED_PRI(FIXED_PRI != 0)) u_pick (
    .req0(req0),
    .req1(req1),
    .last_owner(last_owner),
    .exclude_valid(state == S_DONE),
    .exclude_idx(owner),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );
  // Next state and decoded outputs; ACCESS and DONE each last exactly one cycle
  always_comb begin
    take = (state == S_IDLE || state == S_DONE) && grant_valid;
    state_nx = (state == S_ACCESS) ? S_DONE : take ? S_ACCESS : S_IDLE;
    mem_we = (state == S_ACCESS) && l_we;
    ack0 = (state == S_DONE) && owner == PORT_CPU;
    ack1 = (state == S_DONE) && owner == PORT_DBG;
  end
  // State, latched request, round-robin history and per-port read data
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_IDLE;
      owner <= PORT_CPU;
      last_owner <= PORT_DBG;
      l_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        owner <= grant_idx;
        l_we <= grant_idx ? we1 : we0;
        mem_addr <= grant_idx ? addr1 : addr0;
        mem_wdata <= grant_idx ? wdata1 : wdata0;
      end
      if (state == S_DONE) last_owner <= owner;
      if (state == S_ACCESS && owner == PORT_CPU) rdata0 <= mem_rdata;
      if (state == S_ACCESS && owner == PORT_DBG) rdata1 <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench driving a round-robin and a fixed-priority arbiter in lockstep
module tb_ram_arbiter;
  typedef struct {
    logic        port;
    logic [15:0] data;
  } exp_t;
  localparam logic [15:0] IMG [8] = '{16'h0, 16'h0, 16'h0, 16'h1234, 16'h0, 16'h5555, 16'h0, 16'h0};
  logic clk = 0, n_reset = 0, preload = 1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [2:0] addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic rr_ack0, rr_ack1, rr_mwe, fp_ack0, fp_ack1, fp_mwe;
  logic [2:0] rr_maddr, fp_maddr;
  logic [15:0] rr_rd0, rr_rd1, rr_mwd, rr_mrd, fp_rd0, fp_rd1, fp_mwd, fp_mrd;
  logic [15:0] ram_rr [8];
  logic [15:0] ram_fp [8];
  logic pw_rr = 0, pw_fp = 0;
  exp_t q_rr[$];
  exp_t q_fp[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.FIXED_PRI(0)) u_rr (
    .clk(clk), .n_reset(n_reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(rr_ack0), .ack1(rr_ack1), .rdata0(rr_rd0), .rdata1(rr_rd1),
    .mem_we(rr_mwe), .mem_addr(rr_maddr), .mem_wdata(rr_mwd), .mem_rdata(rr_mrd)
  );
  ram_arbiter #(.FIXED_PRI(1)) u_fp (
    .clk(clk), .n_reset(n_reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(fp_ack0), .ack1(fp_ack1), .rdata0(fp_rd0), .rdata1(fp_rd1),
    .mem_we(fp_mwe), .mem_addr(fp_maddr), .mem_wdata(fp_mwd), .mem_rdata(fp_mrd)
  );

  assign rr_mrd = ram_rr[rr_maddr];
  assign fp_mrd = ram_fp[fp_maddr];
  // RAM models: combinational read, store on the rising edge
  always @(posedge clk) begin
    if (preload) ram_rr <= IMG;
    else if (rr_mwe) ram_rr[rr_maddr] <= rr_mwd;
    if (preload) ram_fp <= IMG;
    else if (fp_mwe) ram_fp[fp_maddr] <= fp_mwd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic port_rr, input logic [15:0] d_rr, input logic port_fp, input logic [15:0] d_fp);
    exp_t a, b;
    a.port = port_rr; a.data = d_rr;
    b.port = port_fp; b.data = d_fp;
    q_rr.push_back(a);
    q_fp.push_back(b);
  endtask

  task automatic mon(input bit d, input string tag, input logic a0, input logic a1, input logic we,
                     input logic pw, input logic [15:0] r0, input logic [15:0] r1);
    exp_t e;
    int sz;
    if (we) chk({tag, "_we_gap"}, pw, 0);
    if (a0 || a1) begin
      chk({tag, "_one_ack"}, a0 && a1, 0);
      sz = d ? q_fp.size() : q_rr.size();
      if (sz == 0) begin
        n_chk++;
        $display("FAIL %s_unexpected_ack: got ack0=%0b ack1=%0b expected none", tag, a0, a1);
      end else begin
        if (d) e = q_fp.pop_front();
        else e = q_rr.pop_front();
        chk({tag, "_ack_port"}, a1, e.port);
        chk({tag, "_rdata"}, a1 ? r1 : r0, e.data);
      end
    end
  endtask

  // Monitor: compare every ack against the head of its scoreboard queue
  always @(negedge clk) begin
    mon(0, "rr", rr_ack0, rr_ack1, rr_mwe, pw_rr, rr_rd0, rr_rd1);
    mon(1, "fp", fp_ack0, fp_ack1, fp_mwe, pw_fp, fp_rd0, fp_rd1);
    pw_rr <= rr_mwe;
    pw_fp <= fp_mwe;
  end

  task automatic do_acc(input logic p, input logic w, input logic [2:0] a, input logic [15:0] d);
    bit got = 0;
    @(negedge clk);
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = p ? rr_ack1 : rr_ack0;
    end
    chk("ack_timeout", got, 1);
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    preload = 0;
    chk("rst_ack0", rr_ack0, 0);
    chk("rst_ack1", rr_ack1, 0);
    chk("rst_rdata0", rr_rd0, 0);
    chk("rst_mem_we", rr_mwe, 0);
    chk("rst_mem_addr", fp_maddr, 0);
    n_reset = 1;
    // single read port 0, addr 3
    push(0, 16'h1234, 0, 16'h1234);
    @(negedge clk);
    req0 = 1; addr0 = 3;
    @(posedge clk); #1;
    chk("rd_mem_addr", rr_maddr, 3);
    chk("rd_mem_we", rr_mwe, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rd_ack0", rr_ack0, 1);
    chk("rd_ack1", rr_ack1, 0);
    chk("rd_rdata0", fp_rd0, 16'h1234);
    req0 = 0;
    // single write port 1, addr 7; rdata1 returns the old cell value
    push(1, 16'h0, 1, 16'h0);
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 7; wdata1 = 16'hBEEF;
    @(posedge clk); #1;
    chk("wr_mem_we", rr_mwe, 1);
    chk("wr_mem_addr", rr_maddr, 7);
    chk("wr_mem_wdata", rr_mwd, 16'hBEEF);
    chk("wr_fp_mem_we", fp_mwe, 1);
    @(posedge clk); #1;
    chk("wr_mem_we_off", rr_mwe, 0);
    chk("wr_ack1", rr_ack1, 1);
    @(negedge clk);
    req1 = 0; we1 = 0;
    push(0, 16'hBEEF, 0, 16'hBEEF);
    do_acc(0, 0, 7, 0);
    // one-cycle tie after a port 0 access: round-robin picks 1, fixed priority picks 0
    push(1, 16'hBEEF, 0, 16'h1234);
    @(negedge clk);
    req0 = 1; addr0 = 3; req1 = 1; addr1 = 7;
    @(negedge clk);
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("tie_rr_ack1", rr_ack1, 1);
    chk("tie_fp_ack0", fp_ack0, 1);
    repeat (2) @(negedge clk);
    // asynchronous reset in the ACCESS cycle of a write to addr 5
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 16'hDEAD;
    @(posedge clk); #2;
    chk("arst_pre_we", rr_mwe, 1);
    n_reset = 0;
    #1;
    chk("arst_mem_we", rr_mwe, 0);
    chk("arst_fp_mem_we", fp_mwe, 0);
    chk("arst_ack0", rr_ack0, 0);
    chk("arst_rdata0", rr_rd0, 0);
    chk("arst_rdata1", rr_rd1, 0);
    chk("arst_mem_addr", rr_maddr, 0);
    chk("arst_mem_wdata", rr_mwd, 0);
    req0 = 0; we0 = 0;
    @(negedge clk);
    n_reset = 1;
    @(negedge clk);
    chk("arst_cell5", ram_rr[5], 16'h5555);
    chk("arst_fp_cell5", ram_fp[5], 16'h5555);
    // both ports requesting continuously from reset: 0,1,0,1 two cycles apart
    push(0, 16'h1234, 0, 16'h1234);
    push(1, 16'hBEEF, 1, 16'hBEEF);
    push(0, 16'h1234, 0, 16'h1234);
    push(1, 16'hBEEF, 1, 16'hBEEF);
    req0 = 1; addr0 = 3; req1 = 1; addr1 = 7;
    @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("both_rr_ack0", rr_ack0, j % 4 == 1);
      chk("both_rr_ack1", rr_ack1, j % 4 == 3);
      chk("both_fp_ack0", fp_ack0, j % 4 == 1);
      chk("both_fp_ack1", fp_ack1, j % 4 == 3);
      if (j == 7) begin req0 = 0; req1 = 0; end
    end
    // lone continuous requester: served every 3 cycles
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(0, 16'h1234, 0, 16'h1234);
    req0 = 1; addr0 = 3;
    @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("solo_rr_ack0", rr_ack0, j % 3 == 1);
      chk("solo_fp_ack0", fp_ack0, j % 3 == 1);
      if (j == 7) req0 = 0;
    end
    // request dropped during ACCESS: write still lands, ack still pulses once
    @(negedge clk);
    push(0, 16'h0, 0, 16'h0);
    req0 = 1; we0 = 1; addr0 = 2; wdata0 = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    req0 = 0; we0 = 0;
    @(negedge clk);
    chk("drop_ack0", rr_ack0, 1);
    repeat (4) @(negedge clk);
    chk("drop_cell2", ram_rr[2], 16'h00FF);
    chk("drop_fp_cell2", ram_fp[2], 16'h00FF);
    chk("rr_queue_empty", q_rr.size(), 0);
    chk("fp_queue_empty", q_fp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the 8-word × 16-bit data RAM between the CPU data port (port 0) and a debug/loader port (port 1). It sits between the requesters and the RAM's single write/read port. It serialises accesses through a small state machine, issues exactly one RAM cycle per granted request, and returns read data with a one-cycle acknowledge pulse. It uses round-robin or fixed-priority selection.

## Interface
- `ADDR_W`, default 3: RAM address width (8 cells).
- `DATA_W`, default 16: data word width.
- `FIXED_PRI`, default 0: 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: access request; held high until the matching ack.
- `we0` / `we1` in 1: 1 = write, 0 = read; stable while req is high.
- `addr0` / `addr1` in ADDR_W: cell address; stable while req is high.
- `wdata0` / `wdata1` in DATA_W: write data; stable while req is high.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata0` / `rdata1` out DATA_W: read result, valid while ack is high.
- `mem_we` out 1: RAM store enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM combinational read data.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE:**
  - No req: stay in IDLE.
  - Any req: pick a winner, latch its we/addr/wdata and the owner index, then go to ACCESS.
- **ACCESS** (exactly one cycle):
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_we = latched we.
  - At the clock edge, mem_rdata is captured into the owner's rdata register. Go to DONE.
- **DONE** (exactly one cycle):
  - ack of the owner is high; the other ack is low.
  - last_owner ← owner.
  - Arbitration considers only the non-owner's req. If it is high, latch it and go to ACCESS; otherwise go to IDLE.
- **Round-robin:** on a tie, the port that is not last_owner wins. last_owner resets to 1, so port 0 wins the first tie.
- **FIXED_PRI=1:** port 0 wins ties. The DONE-state owner exclusion still applies, so port 1 is served after every port 0 access.
- **Write accesses:** rdata of the owner is still updated with mem_rdata, i.e. the old cell value, since the store lands at the same edge.
- **Req dropped before ack:** the access completes anyway and ack still pulses. A write is not cancelled.
- **Req still high in the cycle after ack:** treated as a new request.
- Outside ACCESS: mem_we = 0, and mem_addr/mem_wdata hold their last latched values.

## Timing
- Reset values: state = IDLE, ack0/1 = 0, rdata0/1 = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, last_owner = 1.
- Reset is asynchronous. Asserting n_reset mid-ACCESS drops mem_we immediately, aborts the access, and no ack is issued.
- Latency: req sampled high at edge k → ACCESS during cycle k..k+1 → ack high during cycle k+1..k+2. That is 2 cycles from the sampling edge.
- Throughput:
  - One RAM access every 2 cycles.
  - Both ports requesting continuously alternate: 0,1,0,1… with each port acked every 4 cycles.
  - A single continuous requester is served every 3 cycles (IDLE re-entry).
- mem_we is never high for two consecutive cycles.

## Structure
- Shared package `cpu_pkg`:
  - State encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2.
  - Port index constants PORT_CPU=0, PORT_DBG=1.
  - RAM geometry constants RAM_ADDR_W=3, RAM_DATA_W=16.
- One combinational sub-module, `ram_arb_pick`:
  - Inputs: req0, req1, last_owner, FIXED_PRI, exclude_valid, exclude_idx.
  - Outputs: grant_valid, grant_idx.
  - Used in both IDLE and DONE.
- The remainder is the state register, latch registers and output decode.

## Test plan
- **Reset:**
  - Drive n_reset low mid-ACCESS of a write to addr 5.
  - Expect mem_we=0 within the same cycle, no ack, and all outputs at reset values.
  - Cell 5 is unchanged.
- **Single read:**
  - Preload cell 3 = 16'h1234; req0 read addr 3.
  - Expect mem_addr=3 in the ACCESS cycle, then ack0=1 and rdata0=16'h1234 2 cycles after the sampling edge.
  - ack1 stays 0.
- **Single write:**
  - req1 write addr 7, wdata 16'hBEEF.
  - Expect mem_we high for exactly one cycle and ack1 one cycle later.
  - A following req0 read addr 7 returns 16'hBEEF.
- **Simultaneous requests after reset, round-robin:**
  - Hold req0 and req1 continuously.
  - Expect grant order 0,1,0,1 with ack pulses 2 cycles apart, alternating ports.
  - No cycle has both acks high.
- **FIXED_PRI=1 with both requesting:**
  - Expect order 0,1,0,1; port 1 is never starved.
  - With only req0 held: ack0 every 3 cycles.
- **Early drop:**
  - req0 write addr 2, wdata 16'h00FF, with req0 dropped in the ACCESS cycle.
  - Expect the write still committed (cell 2 = 16'h00FF), ack0 still pulses, and no second access.
